// File: rtl/otg_hpi_ctrl.sv
// otg_hpi_ctrl: Avalon-MM slave that turns each read/write into one timed
// CY7C67200 HPI bus cycle (SETUP -> STROBE -> HOLD -> DONE -> RECOVER).
// Optional interrupt pass-through is enabled with `define OTG_HPI_IRQ_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | bus idle, waiting for an Avalon request to latch
// SETUP   | cs_n low, address (and write data) valid before strobe
// STROBE  | r_n or w_n low; read data captured on the last clock
// HOLD    | strobe released, cs_n/address/data still held
// DONE    | bus released, waitrequest low for one clock
// RECOVER | enforced idle gap before the next HPI cycle
module otg_hpi_ctrl #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [1:0]  otg_hpi_address,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in
`ifdef OTG_HPI_IRQ_EN
    ,
    input  logic        otg_hpi_int,
    output logic        irq
`endif
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [15:0]     readdata_q, readdata_d;

    logic            cs_n_q, cs_n_d;
    logic            r_n_q, r_n_d;
    logic            w_n_q, w_n_d;
    logic            oe_q, oe_d;
    logic [1:0]      haddr_q, haddr_d;
    logic [15:0]     hdata_q, hdata_d;

    logic            req;
    logic            busy_d;

    // A write wins when read and write are both raised.
    assign req = chipselect & (read | write);

    // Stall every request except in the single DONE clock.
    assign waitrequest = req & (state_q != S_DONE);

    // State, down-counter and latched transfer fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
        end
    end

    // Next-state: each phase loads its length-1 and leaves on terminal count.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    addr_d  = address;
                    wr_d    = write;
                    if (write) begin
                        wdata_d = writedata;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    if (!wr_q) begin
                        readdata_d = otg_hpi_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (RECOVER_CYC == 0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_RECOVER;
                    cnt_d   = CW'(RECOVER_CYC - 1);
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // HPI pin values decoded from the next state so the pins are glitch-free flops.
    always_comb begin
        busy_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cs_n_d  = ~busy_d;
        r_n_d   = ~((state_d == S_STROBE) & ~wr_d);
        w_n_d   = ~((state_d == S_STROBE) &  wr_d);
        oe_d    = busy_d & wr_d;
        haddr_d = addr_d;
        hdata_d = wdata_d;
    end

    // HPI pin registers; reset forces the bus idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n_q  <= 1'b1;
            r_n_q   <= 1'b1;
            w_n_q   <= 1'b1;
            oe_q    <= 1'b0;
            haddr_q <= '0;
            hdata_q <= '0;
        end else begin
            cs_n_q  <= cs_n_d;
            r_n_q   <= r_n_d;
            w_n_q   <= w_n_d;
            oe_q    <= oe_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
        end
    end

    assign readdata         = readdata_q;
    assign otg_hpi_cs_n     = cs_n_q;
    assign otg_hpi_r_n      = r_n_q;
    assign otg_hpi_w_n      = w_n_q;
    assign otg_hpi_data_oe  = oe_q;
    assign otg_hpi_address  = haddr_q;
    assign otg_hpi_data_out = hdata_q;

`ifdef OTG_HPI_IRQ_EN
    logic [1:0] int_sync_q;

    // Two-flop synchronizer for the asynchronous HPI interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_sync_q <= '0;
        end else begin
            int_sync_q <= {int_sync_q[0], otg_hpi_int};
        end
    end

    assign irq = int_sync_q[1];
`endif

endmodule
